// File: rtl/worker_mem_responder_if.sv
// Avalon-MM pipelined-read bus between the worker's master port and the
// on-chip memory responder. Single clock domain; signals are plain wires.
interface worker_mem_responder_if;
   logic        waitrequest;
   logic [31:0] readdata;
   logic        readdatavalid;
   logic        burstcount;
   logic [31:0] writedata;
   logic [27:0] address;
   logic        write;
   logic        read;
   logic [3:0]  byteenable;
   logic        debugaccess;

   modport master (
      input  waitrequest, readdata, readdatavalid,
      output burstcount, writedata, address, write, read, byteenable, debugaccess
   );

   modport slave (
      output waitrequest, readdata, readdatavalid,
      input  burstcount, writedata, address, write, read, byteenable, debugaccess
   );
endinterface

// File: rtl/worker_mem_responder.sv
// Avalon-MM pipelined-read responder backed by a word-addressed on-chip
// memory. Reads return after a fixed latency, in order, with up to
// MAX_PENDING in flight; waitrequest throttles the master beyond that.
// Debug counters track accepted reads/writes and protocol/range errors.
module worker_mem_responder #(
   parameter int          ADDR_W       = 10,
   parameter int          READ_LATENCY = 2,
   parameter int          MAX_PENDING  = 4,
   parameter logic [31:0] OOR_DATA     = 32'hDEADBEEF
) (
   input  logic                         clk_clk,
   input  logic                         reset_reset,
   worker_mem_responder_if.slave        slave,
   output logic [15:0]                  rd_count,
   output logic [15:0]                  wr_count,
   output logic [7:0]                   err_count
);

   localparam int         DEPTH = 2 ** ADDR_W;
   localparam logic [4:0] MAX_P = 5'(MAX_PENDING);

   logic [31:0]       mem [DEPTH];
   logic [ADDR_W-1:0] word;
   logic              oor;

   logic              accept;
   logic              rd_acc;
   logic              wr_acc;
   logic              err_ev;
   logic [31:0]       rd_word;
   logic [3:0]        outstanding;
   logic [4:0]        out_next;

   logic [READ_LATENCY-1:0] pipe_v;
   logic [31:0]             pipe_d [READ_LATENCY];

   // Inputs that carry no meaning for this responder.
   logic unused_ok;
   assign unused_ok = ^{slave.burstcount, slave.debugaccess, slave.address[1:0]};

   assign word = slave.address[ADDR_W+1:2];
   assign oor  = |slave.address[27:ADDR_W+2];

   // Decode the command accepted this cycle and the next in-flight count.
   // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
   always_comb begin
      accept   = 1'b0;
      rd_acc   = 1'b0;
      wr_acc   = 1'b0;
      err_ev   = 1'b0;
      rd_word  = OOR_DATA;
      out_next = 5'(outstanding);
      accept   = (slave.read | slave.write) & ~slave.waitrequest;
      wr_acc   = accept & slave.write;
      // A simultaneous read+write keeps the write and drops the read.
      rd_acc   = accept & slave.read & ~slave.write;
      err_ev   = accept & ((slave.read & slave.write) | oor);
      if (!oor) rd_word = mem[word];
      // A response leaving the pipeline frees its slot on the same edge.
      out_next = 5'(outstanding) + 5'(rd_acc) - 5'(pipe_v[READ_LATENCY-1]);
   end

   // Byte-lane writes into the storage array; a read in the next cycle sees the new data.
   // NOTE: the memory array has no reset; clearing it would force a huge reset tree and contents must survive reset.
   always_ff @(posedge clk_clk) begin
      if (wr_acc && !oor) begin
         for (int i = 0; i < 4; i++) begin
            if (slave.byteenable[i]) mem[word][8*i +: 8] <= slave.writedata[8*i +: 8];
         end
      end
   end

   // Read pipeline, response register, outstanding tracking and waitrequest.
   // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         pipe_v              <= '0;
         for (int i = 0; i < READ_LATENCY; i++) pipe_d[i] <= '0;
         slave.readdatavalid <= 1'b0;
         slave.readdata      <= '0;
         slave.waitrequest   <= 1'b1;
         outstanding         <= '0;
      end else begin
         pipe_v[0] <= rd_acc;
         pipe_d[0] <= rd_word;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
         end
         slave.readdatavalid <= pipe_v[READ_LATENCY-1];
         if (pipe_v[READ_LATENCY-1]) slave.readdata <= pipe_d[READ_LATENCY-1];
         outstanding       <= out_next[3:0];
         slave.waitrequest <= (out_next >= MAX_P);
      end
   end

   // Debug counters: access counts wrap, error count saturates.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         rd_count  <= '0;
         wr_count  <= '0;
         err_count <= '0;
      end else begin
         rd_count <= rd_count + 16'(rd_acc);
         wr_count <= wr_count + 16'(wr_acc);
         if (err_ev && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_worker_mem_responder.sv
// Directed bench for worker_mem_responder: reset behaviour, byte-lane
// writes, read latency, pipelined reads, read-after-write, out-of-range
// access, read+write collision, MAX_PENDING=1 throttling and mid-flight reset.
module tb_worker_mem_responder;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   logic [15:0] rd_a, wr_a, rd_b, wr_b;
   logic [7:0]  err_a, err_b;

   worker_mem_responder_if bus_a ();
   worker_mem_responder_if bus_b ();

   worker_mem_responder #(.MAX_PENDING(4)) dut_a (
      .clk_clk(clk), .reset_reset(rst), .slave(bus_a),
      .rd_count(rd_a), .wr_count(wr_a), .err_count(err_a)
   );

   worker_mem_responder #(.MAX_PENDING(1)) dut_b (
      .clk_clk(clk), .reset_reset(rst), .slave(bus_b),
      .rd_count(rd_b), .wr_count(wr_b), .err_count(err_b)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [27:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        exp_v;
      logic [31:0] exp_d;
   } vec_t;

   vec_t tbl [15];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_a(input logic rd, input logic wr, input logic [27:0] addr,
                          input logic [31:0] wd, input logic [3:0] be);
      bus_a.read = rd; bus_a.write = wr; bus_a.address = addr;
      bus_a.writedata = wd; bus_a.byteenable = be;
   endtask

   task automatic drive_b(input logic rd, input logic wr, input logic [27:0] addr,
                          input logic [31:0] wd, input logic [3:0] be);
      bus_b.read = rd; bus_b.write = wr; bus_b.address = addr;
      bus_b.writedata = wd; bus_b.byteenable = be;
   endtask

   // Single read on dut_a, response expected exactly two edges after acceptance.
   task automatic read_a(input string name, input logic [27:0] addr, input logic [31:0] exp);
      drive_a(1'b1, 1'b0, addr, 32'h0, 4'h0);
      tick();
      drive_a(1'b0, 1'b0, 28'h0, 32'h0, 4'h0);
      tick();
      check({name, "_early"}, 32'(bus_a.readdatavalid), 32'd0);
      tick();
      check({name, "_valid"}, 32'(bus_a.readdatavalid), 32'd1);
      check({name, "_data"}, bus_a.readdata, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int seen;

      // Back-to-back cycles on dut_a; expectations observed just after each edge.
      tbl[0]  = '{rd:1'b0, wr:1'b1, addr:28'h00, wdata:32'h11111111, be:4'hF, exp_v:1'b0, exp_d:32'h1234CC78};
      tbl[1]  = '{rd:1'b0, wr:1'b1, addr:28'h04, wdata:32'h22222222, be:4'hF, exp_v:1'b0, exp_d:32'h1234CC78};
      tbl[2]  = '{rd:1'b1, wr:1'b0, addr:28'h00, wdata:32'h0,        be:4'h0, exp_v:1'b0, exp_d:32'h1234CC78};
      tbl[3]  = '{rd:1'b1, wr:1'b0, addr:28'h04, wdata:32'h0,        be:4'h0, exp_v:1'b0, exp_d:32'h1234CC78};
      tbl[4]  = '{rd:1'b1, wr:1'b0, addr:28'h10, wdata:32'h0,        be:4'h0, exp_v:1'b1, exp_d:32'h11111111};
      tbl[5]  = '{rd:1'b1, wr:1'b0, addr:28'h00, wdata:32'h0,        be:4'h0, exp_v:1'b1, exp_d:32'h22222222};
      tbl[6]  = '{rd:1'b1, wr:1'b0, addr:28'h04, wdata:32'h0,        be:4'h0, exp_v:1'b1, exp_d:32'h1234CC78};
      tbl[7]  = '{rd:1'b1, wr:1'b0, addr:28'h10, wdata:32'h0,        be:4'h0, exp_v:1'b1, exp_d:32'h11111111};
      tbl[8]  = '{rd:1'b0, wr:1'b0, addr:28'h00, wdata:32'h0,        be:4'h0, exp_v:1'b1, exp_d:32'h22222222};
      tbl[9]  = '{rd:1'b0, wr:1'b0, addr:28'h00, wdata:32'h0,        be:4'h0, exp_v:1'b1, exp_d:32'h1234CC78};
      tbl[10] = '{rd:1'b0, wr:1'b1, addr:28'h04, wdata:32'h33333333, be:4'hF, exp_v:1'b0, exp_d:32'h1234CC78};
      tbl[11] = '{rd:1'b1, wr:1'b0, addr:28'h04, wdata:32'h0,        be:4'h0, exp_v:1'b0, exp_d:32'h1234CC78};
      tbl[12] = '{rd:1'b0, wr:1'b0, addr:28'h00, wdata:32'h0,        be:4'h0, exp_v:1'b0, exp_d:32'h1234CC78};
      tbl[13] = '{rd:1'b0, wr:1'b0, addr:28'h00, wdata:32'h0,        be:4'h0, exp_v:1'b1, exp_d:32'h33333333};
      tbl[14] = '{rd:1'b0, wr:1'b0, addr:28'h00, wdata:32'h0,        be:4'h0, exp_v:1'b0, exp_d:32'h33333333};

      rst = 1'b1;
      bus_a.burstcount = 1'b1; bus_a.debugaccess = 1'b0;
      bus_b.burstcount = 1'b1; bus_b.debugaccess = 1'b0;
      drive_a(1'b0, 1'b0, 28'h0, 32'h0, 4'h0);
      drive_b(1'b0, 1'b0, 28'h0, 32'h0, 4'h0);

      // ---- Reset values and release ----
      tick();
      tick();
      check("rst_wait", 32'(bus_a.waitrequest), 32'd1);
      check("rst_rdv", 32'(bus_a.readdatavalid), 32'd0);
      check("rst_rdata", bus_a.readdata, 32'h0);
      check("rst_counts", {rd_a, wr_a}, 32'h0);
      check("rst_err", 32'(err_a), 32'd0);
      rst = 1'b0;
      #1;
      check("rel_wait_held", 32'(bus_a.waitrequest), 32'd1);
      tick();
      check("rel_wait_a", 32'(bus_a.waitrequest), 32'd0);
      check("rel_wait_b", 32'(bus_b.waitrequest), 32'd0);

      // ---- Byte-lane write then read with exact latency ----
      drive_a(1'b0, 1'b1, 28'h10, 32'h12345678, 4'hF);
      tick();
      drive_a(1'b0, 1'b1, 28'h10, 32'hAABBCCDD, 4'b0010);
      tick();
      drive_a(1'b1, 1'b0, 28'h10, 32'h0, 4'h0);
      tick();
      drive_a(1'b0, 1'b0, 28'h0, 32'h0, 4'h0);
      check("be_lat0", 32'(bus_a.readdatavalid), 32'd0);
      tick();
      check("be_lat1", 32'(bus_a.readdatavalid), 32'd0);
      tick();
      check("be_lat2", 32'(bus_a.readdatavalid), 32'd1);
      check("be_data", bus_a.readdata, 32'h1234CC78);
      check("be_counts", {rd_a, wr_a}, {16'd1, 16'd2});
      tick();
      check("be_one_cycle", 32'(bus_a.readdatavalid), 32'd0);
      check("be_hold", bus_a.readdata, 32'h1234CC78);

      // ---- Pipelined reads and read-after-write ----
      for (int i = 0; i < 15; i++) begin
         drive_a(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be);
         tick();
         check($sformatf("tbl%0d_wait", i), 32'(bus_a.waitrequest), 32'd0);
         check($sformatf("tbl%0d_rdv", i), 32'(bus_a.readdatavalid), 32'(tbl[i].exp_v));
         check($sformatf("tbl%0d_data", i), bus_a.readdata, tbl[i].exp_d);
      end
      drive_a(1'b0, 1'b0, 28'h0, 32'h0, 4'h0);
      check("tbl_counts", {rd_a, wr_a}, {16'd8, 16'd5});

      // ---- Out-of-range read and write ----
      read_a("oor_rd", 28'h0100_0000, 32'hDEADBEEF);
      check("oor_rd_err", 32'(err_a), 32'd1);
      read_a("oor_rd_mem", 28'h0, 32'h11111111);
      drive_a(1'b0, 1'b1, 28'h0100_0004, 32'h99, 4'hF);
      tick();
      drive_a(1'b0, 1'b0, 28'h0, 32'h0, 4'h0);
      check("oor_wr_err", 32'(err_a), 32'd2);
      check("oor_wr_cnt", 32'(wr_a), 32'd6);
      read_a("oor_wr_mem", 28'h4, 32'h33333333);

      // ---- Read and write together ----
      drive_a(1'b1, 1'b1, 28'h20, 32'h55, 4'hF);
      tick();
      drive_a(1'b0, 1'b0, 28'h0, 32'h0, 4'h0);
      check("rw_err", 32'(err_a), 32'd3);
      check("rw_counts", {rd_a, wr_a}, {16'd11, 16'd7});
      seen = 0;
      repeat (4) begin
         tick();
         if (bus_a.readdatavalid) seen++;
      end
      check("rw_no_resp", 32'(seen), 32'd0);
      read_a("rw_mem", 28'h20, 32'h55);

      // ---- MAX_PENDING=1: master holds read, one response per 3 cycles ----
      drive_b(1'b0, 1'b1, 28'h0, 32'hA0, 4'hF);
      tick();
      drive_b(1'b0, 1'b1, 28'h4, 32'hA1, 4'hF);
      tick();
      drive_b(1'b0, 1'b1, 28'h8, 32'hA2, 4'hF);
      tick();
      drive_b(1'b1, 1'b0, 28'h0, 32'h0, 4'h0);
      for (int k = 0; k < 9; k++) begin
         tick();
         check($sformatf("mp1_wait%0d", k), 32'(bus_b.waitrequest), 32'((k % 3) != 2));
         check($sformatf("mp1_rdv%0d", k), 32'(bus_b.readdatavalid), 32'((k % 3) == 2));
         if ((k % 3) == 2) check($sformatf("mp1_data%0d", k), bus_b.readdata, 32'(32'hA0 + k / 3));
         if ((k % 3) == 0) bus_b.address = 28'(4 * (k / 3 + 1));
      end
      drive_b(1'b0, 1'b0, 28'h0, 32'h0, 4'h0);
      check("mp1_counts", {rd_b, wr_b}, {16'd3, 16'd3});

      // ---- Reset with reads in flight ----
      drive_a(1'b1, 1'b0, 28'h00, 32'h0, 4'h0);
      tick();
      drive_a(1'b1, 1'b0, 28'h04, 32'h0, 4'h0);
      tick();
      drive_a(1'b1, 1'b0, 28'h20, 32'h0, 4'h0);
      tick();
      drive_a(1'b0, 1'b0, 28'h0, 32'h0, 4'h0);
      rst = 1'b1;
      #1;
      check("mid_rst_rdv", 32'(bus_a.readdatavalid), 32'd0);
      check("mid_rst_wait", 32'(bus_a.waitrequest), 32'd1);
      check("mid_rst_counts", {rd_a, wr_a}, 32'h0);
      tick();
      tick();
      rst = 1'b0;
      seen = 0;
      repeat (6) begin
         tick();
         if (bus_a.readdatavalid) seen++;
      end
      check("mid_rst_no_resp", 32'(seen), 32'd0);
      check("mid_rst_outstanding", 32'(dut_a.outstanding), 32'd0);
      check("mid_rst_wait_rel", 32'(bus_a.waitrequest), 32'd0);
      read_a("mid_rst_mem20", 28'h20, 32'h55);
      read_a("mid_rst_mem10", 28'h10, 32'h1234CC78);
      check("mid_rst_rdcnt", 32'(rd_a), 32'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
